riscv_lsu: RTL and testbench

Load-store unit for the RV32 core. It sits downstream of the instruction decoder, which supplies `mem_req`, `mem_we` and `mem_size`, and upstream of the data-memory port. The unit converts byte, half and word accesses into word-aligned memory transactions with byte enables. It stalls the core until the memory responds, then aligns and sign- or zero-extends load data for register writeback.

---
 rtl/riscv_pkg.sv | 52 +++++
 rtl/lsu_load_align.sv | 37 +++
 rtl/riscv_lsu.sv | 122 ++++++++++++
 tb/tb_riscv_lsu.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: load/store size codes, LSU state encoding
// and the byte-lane helpers used by the load-store unit.
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  localparam int LSU_BE_W = 4;

  typedef enum logic [1:0] {
    LSU_IDLE        = 2'b00,
    LSU_WAIT_GNT    = 2'b01,
    LSU_WAIT_RVALID = 2'b10
  } lsu_state_t;

  // Illegal size codes are reported exactly like misaligned accesses.
  function automatic logic lsuLegal(input logic [2:0] size, input logic [1:0] offset);
    logic legal;
    case (size)
      LDST_B, LDST_BU: legal = 1'b1;
      LDST_H, LDST_HU: legal = ~offset[0];
      LDST_W:          legal = (offset == 2'b00);
      default:         legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic [LSU_BE_W-1:0] lsuBe(input logic [2:0] size, input logic [1:0] offset);
    logic [LSU_BE_W-1:0] be;
    case (size)
      LDST_B, LDST_BU: be = 4'b0001 << offset;
      LDST_H, LDST_HU: be = 4'b0011 << {offset[1], 1'b0};
      LDST_W:          be = 4'b1111;
      default:         be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lsuWdata(input logic [2:0] size, input logic [31:0] data);
    logic [31:0] wdata;
    case (size)
      LDST_B, LDST_BU: wdata = {4{data[7:0]}};
      LDST_H, LDST_HU: wdata = {2{data[15:0]}};
      default:         wdata = data;
    endcase
    return wdata;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  output logic [31:0] result
);

  logic [7:0]  byteSel_s;
  logic [15:0] halfSel_s;

  // Lane selection and extension of the returned word
  always_comb begin
    case (offset)
      2'b00:   byteSel_s = rdata[7:0];
      2'b01:   byteSel_s = rdata[15:8];
      2'b10:   byteSel_s = rdata[23:16];
      2'b11:   byteSel_s = rdata[31:24];
      default: byteSel_s = 8'h00;
    endcase
    if (offset[1]) begin
      halfSel_s = rdata[31:16];
    end else begin
      halfSel_s = rdata[15:0];
    end
    case (size)
      LDST_B:  result = {{24{byteSel_s[7]}}, byteSel_s};
      LDST_BU: result = {24'h000000, byteSel_s};
      LDST_H:  result = {{16{halfSel_s[15]}}, halfSel_s};
      LDST_HU: result = {16'h0000, halfSel_s};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// RV32 load-store unit: one outstanding word-aligned memory transaction,
// byte-enable generation, store lane replication and load extension.
module riscv_lsu
  import riscv_pkg::*;
(
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [2:0]          lsu_size_i,
  input  logic [31:0]         lsu_addr_i,
  input  logic [31:0]         lsu_data_i,
  output logic [31:0]         lsu_data_o,
  output logic                lsu_stall_req_o,
  output logic                lsu_misalign_o,
  output logic                data_req_o,
  output logic                data_we_o,
  output logic [LSU_BE_W-1:0] data_be_o,
  output logic [31:0]         data_addr_o,
  output logic [31:0]         data_wdata_o,
  input  logic                data_gnt_i,
  input  logic                data_rvalid_i,
  input  logic [31:0]         data_rdata_i
);

  lsu_state_t          state_r;
  logic [31:0]         reqAddr_r;
  logic [31:0]         reqWdata_r;
  logic [LSU_BE_W-1:0] reqBe_r;
  logic [2:0]          reqSize_r;
  logic                reqWe_r;
  logic [31:0]         loadData_r;

  logic                accessLegal_s;
  logic                issue_s;
  logic                complete_s;
  logic [31:0]         alignedData_s;

  assign accessLegal_s = lsuLegal(lsu_size_i, lsu_addr_i[1:0]);
  assign issue_s       = (state_r == LSU_IDLE) & lsu_req_i & accessLegal_s;
  assign complete_s    = (state_r == LSU_WAIT_RVALID) & data_rvalid_i;

  lsu_load_align u_loadAlign (
    .rdata  (data_rdata_i),
    .offset (reqAddr_r[1:0]),
    .size   (reqSize_r),
    .result (alignedData_s)
  );

  // Memory port: live decoder fields in the issue cycle, captured fields afterwards
  always_comb begin
    data_req_o   = 1'b0;
    data_we_o    = reqWe_r;
    data_be_o    = reqBe_r;
    data_addr_o  = {reqAddr_r[31:2], 2'b00};
    data_wdata_o = reqWdata_r;
    if (issue_s) begin
      data_req_o   = 1'b1;
      data_we_o    = lsu_we_i;
      data_be_o    = lsuBe(lsu_size_i, lsu_addr_i[1:0]);
      data_addr_o  = {lsu_addr_i[31:2], 2'b00};
      data_wdata_o = lsuWdata(lsu_size_i, lsu_data_i);
    end else if (state_r == LSU_WAIT_GNT) begin
      data_req_o = 1'b1;
    end else begin
      data_req_o = 1'b0;
    end
  end

  // Core-side handshake and load result bypass in the completion cycle
  always_comb begin
    lsu_misalign_o  = (state_r == LSU_IDLE) & lsu_req_i & ~accessLegal_s;
    lsu_stall_req_o = issue_s | (state_r == LSU_WAIT_GNT)
                    | ((state_r == LSU_WAIT_RVALID) & ~data_rvalid_i);
    if (complete_s && !reqWe_r) begin
      lsu_data_o = alignedData_s;
    end else begin
      lsu_data_o = loadData_r;
    end
  end

  // Transaction FSM with request capture and load result register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_r    <= LSU_IDLE;
      reqAddr_r  <= 32'h0000_0000;
      reqWdata_r <= 32'h0000_0000;
      reqBe_r    <= 4'b0000;
      reqSize_r  <= 3'b000;
      reqWe_r    <= 1'b0;
      loadData_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        LSU_IDLE: begin
          if (issue_s) begin
            reqAddr_r  <= lsu_addr_i;
            reqWdata_r <= lsuWdata(lsu_size_i, lsu_data_i);
            reqBe_r    <= lsuBe(lsu_size_i, lsu_addr_i[1:0]);
            reqSize_r  <= lsu_size_i;
            reqWe_r    <= lsu_we_i;
            state_r    <= data_gnt_i ? LSU_WAIT_RVALID : LSU_WAIT_GNT;
          end
        end
        LSU_WAIT_GNT: begin
          if (data_gnt_i) begin
            state_r <= LSU_WAIT_RVALID;
          end
        end
        LSU_WAIT_RVALID: begin
          if (data_rvalid_i) begin
            if (!reqWe_r) begin
              loadData_r <= alignedData_s;
            end
            state_r <= LSU_IDLE;
          end
        end
        default: state_r <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed scenarios followed by random
// accesses against a byte-arithmetic reference model.
module tb_riscv_lsu;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        lsuReq, lsuWe;
  logic [2:0]  lsuSize;
  logic [31:0] lsuAddr, lsuData;
  logic [31:0] lsuDataOut;
  logic        stall, misalign;
  logic        dataReq, dataWe;
  logic [3:0]  dataBe;
  logic [31:0] dataAddr, dataWdata;
  logic        dataGnt, dataRvalid;
  logic [31:0] dataRdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] lastLoad = 32'h0;

  always #5 clk = ~clk;

  riscv_lsu dut (
    .clk_i(clk), .rstn_i(rstn),
    .lsu_req_i(lsuReq), .lsu_we_i(lsuWe), .lsu_size_i(lsuSize),
    .lsu_addr_i(lsuAddr), .lsu_data_i(lsuData), .lsu_data_o(lsuDataOut),
    .lsu_stall_req_o(stall), .lsu_misalign_o(misalign),
    .data_req_o(dataReq), .data_we_o(dataWe), .data_be_o(dataBe),
    .data_addr_o(dataAddr), .data_wdata_o(dataWdata),
    .data_gnt_i(dataGnt), .data_rvalid_i(dataRvalid), .data_rdata_i(dataRdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nBytes(input logic [2:0] size);
    if (size[1:0] == 2'b00) return 1;
    if (size[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] expBe(input logic [2:0] size, input logic [31:0] addr);
    int t;
    t = ((1 << nBytes(size)) - 1) << int'(addr[1:0]);
    return t[3:0];
  endfunction

  function automatic logic [31:0] expWdata(input logic [2:0] size, input logic [31:0] d);
    logic [31:0] w;
    int n;
    n = nBytes(size);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] expLoad(input logic [2:0] size, input logic [31:0] addr,
                                          input logic [31:0] rdata);
    logic [31:0] v;
    int n;
    n = nBytes(size);
    v = rdata >> (8 * int'(addr[1:0]));
    if (n == 1) begin
      v = v & 32'h0000_00FF;
      if (!size[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (n == 2) begin
      v = v & 32'h0000_FFFF;
      if (!size[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access with gd cycles of grant delay and rd cycles of rvalid delay
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int gd, input int rd);
    int phase = 0;
    int cnt = 0;
    int reqCyc = 0;
    int stallCyc = 0;
    bit done = 1'b0;
    logic [31:0] ld;
    ld = expLoad(size, addr, rdata);
    lsuReq = 1'b1; lsuWe = we; lsuSize = size; lsuAddr = addr; lsuData = wdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      dataGnt    = (phase == 0) ? (cnt == gd) : 1'($urandom_range(0, 1));
      dataRvalid = (phase == 1) && (cnt == rd);
      dataRdata  = dataRvalid ? rdata : $urandom;
      @(negedge clk);
      if (dataReq) begin
        reqCyc++;
        chk("addr", dataAddr, {addr[31:2], 2'b00});
        chk("be", {28'h0, dataBe}, {28'h0, expBe(size, addr)});
        chk("wdata", dataWdata, expWdata(size, wdata));
        chk("we", {31'h0, dataWe}, {31'h0, we});
      end
      if (stall) stallCyc++;
      chk("misalign_legal", {31'h0, misalign}, 32'h0);
      if (dataRvalid) begin
        chk("stall_at_rvalid", {31'h0, stall}, 32'h0);
        chk("ldata_bypass", lsuDataOut, we ? lastLoad : ld);
        done = 1'b1;
      end
      step();
      if (phase == 0 && dataGnt) begin
        phase = 1;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
    chk("completed", {31'h0, done}, 32'h1);
    chk("req_cycles", reqCyc, gd + 1);
    chk("stall_cycles", stallCyc, gd + rd + 1);
    if (!we) lastLoad = ld;
    lsuReq = 1'b0; dataGnt = 1'b0; dataRvalid = 1'b0;
    chk("ldata_hold", lsuDataOut, lastLoad);
  endtask

  task automatic misTest(input logic [2:0] size, input logic [31:0] addr);
    lsuReq = 1'b1; lsuWe = 1'b0; lsuSize = size; lsuAddr = addr;
    dataGnt = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("mis_pulse", {31'h0, misalign}, 32'h1);
    chk("mis_req", {31'h0, dataReq}, 32'h0);
    chk("mis_stall", {31'h0, stall}, 32'h0);
    step();
    lsuReq = 1'b0; dataGnt = 1'b0;
    @(negedge clk);
    chk("mis_clear", {31'h0, misalign}, 32'h0);
    chk("mis_idle", {31'h0, stall | dataReq}, 32'h0);
    chk("mis_ldata", lsuDataOut, lastLoad);
    step();
  endtask

  initial begin
    logic [2:0] sizes [5];
    sizes = '{LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU};
    rstn = 1'b0; lsuReq = 1'b0; lsuWe = 1'b0; lsuSize = 3'b000;
    lsuAddr = 32'h0; lsuData = 32'h0;
    dataGnt = 1'b0; dataRvalid = 1'b0; dataRdata = 32'h0;
    repeat (3) step();
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ldata", lsuDataOut, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_mis", {31'h0, misalign}, 32'h0);
    chk("rst_req_we", {30'h0, dataReq, dataWe}, 32'h0);
    chk("rst_be", {28'h0, dataBe}, 32'h0);
    chk("rst_addr", dataAddr, 32'h0);
    chk("rst_wdata", dataWdata, 32'h0);
    step();

    access(1'b0, LDST_BU, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0);
    chk("bu_value", lsuDataOut, 32'h0000_0080);
    access(1'b0, LDST_B, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0);
    chk("b_value", lsuDataOut, 32'hFFFF_FF80);
    access(1'b0, LDST_H, 32'h0000_0102, 32'h0, 32'h80FF_1234, 0, 0);
    chk("h_value", lsuDataOut, 32'hFFFF_80FF);
    access(1'b0, LDST_HU, 32'h0000_0102, 32'h0, 32'h80FF_1234, 0, 0);
    chk("hu_value", lsuDataOut, 32'h0000_80FF);
    access(1'b1, LDST_B, 32'h0000_0201, 32'h1234_56AB, 32'h5555_5555, 2, 1);
    chk("store_keeps_ldata", lsuDataOut, 32'h0000_80FF);

    misTest(LDST_W, 32'h0000_0302);
    misTest(LDST_H, 32'h0000_0301);
    misTest(3'b111, 32'h0000_0300);
    misTest(3'b011, 32'h0000_0300);

    // Reset while waiting for rvalid, then a stray rvalid in IDLE
    lsuReq = 1'b1; lsuWe = 1'b0; lsuSize = LDST_W; lsuAddr = 32'h0000_0400;
    dataGnt = 1'b1;
    step();
    dataGnt = 1'b0; lsuReq = 1'b0; rstn = 1'b0;
    step();
    @(negedge clk);
    chk("rst_mid_addr", dataAddr, 32'h0);
    step();
    rstn = 1'b1;
    dataRvalid = 1'b1; dataRdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_rvalid_stall", {31'h0, stall}, 32'h0);
    chk("late_rvalid_ldata", lsuDataOut, 32'h0);
    chk("late_rvalid_req", {31'h0, dataReq}, 32'h0);
    step();
    dataRvalid = 1'b0;
    @(negedge clk);
    chk("after_late_ldata", lsuDataOut, 32'h0);
    step();
    lastLoad = 32'h0;
    access(1'b0, LDST_W, 32'h0000_0404, 32'h0, 32'hCAFE_F00D, 0, 0);
    chk("post_rst_load", lsuDataOut, 32'hCAFE_F00D);

    // Random legal accesses with random latencies and idle gaps carrying stray handshakes
    for (int k = 0; k < 40; k++) begin
      logic [2:0]  sz;
      logic [31:0] a;
      int gap;
      sz = sizes[$urandom_range(0, 4)];
      a  = $urandom;
      if (nBytes(sz) == 2) a[0] = 1'b0;
      if (nBytes(sz) == 4) a[1:0] = 2'b00;
      access(1'($urandom_range(0, 1)), sz, a, $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        dataGnt = 1'($urandom_range(0, 1));
        dataRvalid = 1'($urandom_range(0, 1));
        dataRdata = $urandom;
        @(negedge clk);
        chk("gap_idle", {31'h0, stall | dataReq}, 32'h0);
        chk("gap_ldata", lsuDataOut, lastLoad);
        step();
      end
      dataGnt = 1'b0; dataRvalid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
